// File: rtl/bm_log_pipe_if.sv
// bm_log_pipe_if: handshake and result bundle for bm_log_pipe.
//   Producer side : in_valid, op, a, b  ->  in_ready
//   Consumer side : out_valid, out, out_zero, out_parity, out_illegal, count
//                   <- out_ready
// The master modport is the environment (drives operands and out_ready).
// The slave modport is the pipe (drives in_ready and all results).
interface bm_log_pipe_if #(
  parameter int BITS    = 32,
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         op;
  logic [BITS-1:0]    a;
  logic [BITS-1:0]    b;
  logic               out_valid;
  logic               out_ready;
  logic [BITS-1:0]    out;
  logic               out_zero;
  logic               out_parity;
  logic               out_illegal;
  logic [COUNT_W-1:0] count;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, out_zero, out_parity, out_illegal, count
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, out_zero, out_parity, out_illegal, count
  );
endinterface

// File: rtl/bm_log_pipe.sv
// bm_log_pipe: two-stage elastic bitwise logic unit.
//   Stage 1 captures {op, a, b} on input acceptance.
//   Stage 2 computes the result and its flags from stage 1 and holds them
//   while the consumer stalls. One result per cycle when out_ready stays high.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : in_valid/in_ready/op/a/b in, out_valid/out_ready/out,
//                    out_zero, out_parity, out_illegal, count (saturating
//                    number of delivered results)
// Build option:
//   LOG_NAND_NOR_EN - when defined, opcodes 4/5 compute NAND/NOR. When not
//   defined they return zero with out_illegal set; handshake and count are
//   unaffected.
module bm_log_pipe #(
  parameter int BITS    = 32,
  parameter int COUNT_W = 16
) (
  input logic          clock,
  input logic          reset_n,
  bm_log_pipe_if.slave bus
);

`ifdef LOG_NAND_NOR_EN
  localparam bit NAND_NOR_EN = 1'b1;
`else
  localparam bit NAND_NOR_EN = 1'b0;
`endif

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  function automatic logic op_illegal(input logic [2:0] op);
    op_illegal = !NAND_NOR_EN && ((op == 3'd4) || (op == 3'd5));
  endfunction

  function automatic logic [BITS-1:0] logic_op(input logic [2:0]      op,
                                               input logic [BITS-1:0] a,
                                               input logic [BITS-1:0] b);
    case (op)
      3'd0:    logic_op = a & b;
      3'd1:    logic_op = a | b;
      3'd2:    logic_op = a ^ b;
      3'd3:    logic_op = ~(a ^ b);
      3'd4:    logic_op = NAND_NOR_EN ? ~(a & b) : '0;
      3'd5:    logic_op = NAND_NOR_EN ? ~(a | b) : '0;
      3'd6:    logic_op = ~a;
      default: logic_op = (a & b) | (a ^ b) | (~a | b);
    endcase
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    sat_inc = (v == COUNT_MAX) ? v : v + 1'b1;
  endfunction

  logic               vld_p1;
  logic [2:0]         op_p1;
  logic [BITS-1:0]    a_p1;
  logic [BITS-1:0]    b_p1;

  logic               vld_p2;
  logic [BITS-1:0]    out_p2;
  logic               zero_p2;
  logic               parity_p2;
  logic               illegal_p2;
  logic [COUNT_W-1:0] count_p2;

  logic               load_p1;
  logic               load_p2;
  logic               xfer;
  logic               in_ready;
  logic [BITS-1:0]    res_p1;
  logic               ill_p1;

  // Stage 2 may refill when empty or when its current result leaves this
  // cycle; stage 1 may refill when empty or when it drains into stage 2.
  // This lets a full pipe accept and deliver on the same edge.
  assign load_p2  = vld_p1 && (!vld_p2 || bus.out_ready);
  assign in_ready = !vld_p1 || load_p2;
  assign load_p1  = bus.in_valid && in_ready;
  assign xfer     = vld_p2 && bus.out_ready;

  // ---- stage 1 : operand capture ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
    end else if (load_p1) begin
      vld_p1 <= 1'b1;
    end else if (load_p2) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (load_p1) begin
      op_p1 <= bus.op;
      a_p1  <= bus.a;
      b_p1  <= bus.b;
    end
  end

  assign ill_p1 = op_illegal(op_p1);
  assign res_p1 = ill_p1 ? '0 : logic_op(op_p1, a_p1, b_p1);

  // ---- stage 2 : result and flags ----
  // Result registers carry reset values because they are visible ports.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2     <= 1'b0;
      out_p2     <= '0;
      zero_p2    <= 1'b0;
      parity_p2  <= 1'b0;
      illegal_p2 <= 1'b0;
    end else if (load_p2) begin
      vld_p2     <= 1'b1;
      out_p2     <= res_p1;
      zero_p2    <= (res_p1 == '0);
      parity_p2  <= ^res_p1;
      illegal_p2 <= ill_p1;
    end else if (xfer) begin
      vld_p2     <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_p2 <= '0;
    end else if (xfer) begin
      count_p2 <= sat_inc(count_p2);
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = vld_p2;
  assign bus.out         = out_p2;
  assign bus.out_zero    = zero_p2;
  assign bus.out_parity  = parity_p2;
  assign bus.out_illegal = illegal_p2;
  assign bus.count       = count_p2;

endmodule

// File: tb/tb_bm_log_pipe.sv
// tb_bm_log_pipe: scoreboard bench for bm_log_pipe (BITS=32/COUNT_W=16) plus
// a small BITS=8/COUNT_W=2 instance for counter saturation.
`timescale 1ns/1ps
module tb_bm_log_pipe;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bm_log_pipe_if #(.BITS(32), .COUNT_W(16)) bus ();
  bm_log_pipe #(.BITS(32), .COUNT_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  bm_log_pipe_if #(.BITS(8), .COUNT_W(2)) bus2 ();
  bm_log_pipe #(.BITS(8), .COUNT_W(2)) dut2 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        parity;
    logic        illegal;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  bit   rnd_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic ill);
    exp_t e;
    e.res     = r;
    e.zero    = (r == 32'h0);
    e.parity  = ^r;
    e.illegal = ill;
    return e;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
    ill = 1'b0;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a ^ b);
      3'd4:    r = ~(a & b);
      3'd5:    r = ~(a | b);
      3'd6:    r = ~a;
      default: r = 32'hFFFF_FFFF;  // (a&b)|(a^b)|(~a|b) covers every bit
    endcase
`ifndef LOG_NAND_NOR_EN
    if (op == 3'd4 || op == 3'd5) begin
      r   = 32'h0;
      ill = 1'b1;
    end
`endif
    return mk(r, ill);
  endfunction

  // Output side of the scoreboard: a transfer happens at the next rising
  // edge whenever valid and ready are both seen high at the falling edge.
  always @(negedge clock) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk("out", bus.out, mon_e.res);
        chk("out_zero", bus.out_zero, mon_e.zero);
        chk("out_parity", bus.out_parity, mon_e.parity);
        chk("out_illegal", bus.out_illegal, mon_e.illegal);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input exp_t e);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clock);
    while (!bus.in_ready && waited < 100) begin
      waited++;
      @(negedge clock);
    end
    if (bus.in_ready) q.push_back(e);
    else chk("send_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain_left", q.size(), 0);
    cycles(1);
    chk("drain_valid", bus.out_valid, 1'b0);
  endtask

  logic [31:0] tbl [8];
  logic [31:0] ra, rb;
  logic [2:0]  rop;
  exp_t        e;
  exp_t        bp [4];
  logic [31:0] bpa [4];
  logic [31:0] bpb [4];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = 32'h00F01200; tbl[1] = 32'hFFF0FF34;
    tbl[2] = 32'hFF00ED34; tbl[3] = 32'h00FF12CB;
    tbl[4] = 32'hFF0FEDFF; tbl[5] = 32'h000F00CB;
    tbl[6] = 32'h0F0FEDCB; tbl[7] = 32'hFFFFFFFF;

    bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.op = 3'd0; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b1;

    // Reset values, then idle after release.
    cycles(3);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out", bus.out, 32'h0);
    chk("rst_flags", {bus.out_zero, bus.out_parity, bus.out_illegal}, 3'b000);
    chk("rst_count", bus.count, 16'd0);
    #2 reset_n = 1'b1;
    cycles(3);
    chk("idle_in_ready", bus.in_ready, 1'b1);
    chk("idle_out_valid", bus.out_valid, 1'b0);
    chk("idle_count", bus.count, 16'd0);

    // Directed vector, ops 0..7 back-to-back; results from the fixed table.
    for (int i = 0; i < 8; i++) begin
      e = mk(tbl[i], 1'b0);
`ifndef LOG_NAND_NOR_EN
      if (i == 4 || i == 5) e = mk(32'h0, 1'b1);
`endif
      send(i[2:0], 32'hF0F01234, 32'h0FF0FF00, e);
      if (i == 0) chk("lat_early", bus.out_valid, 1'b0);
      if (i == 1) begin
        chk("lat_valid", bus.out_valid, 1'b1);
        chk("lat_out", bus.out, 32'h00F01200);
        chk("lat_parity", bus.out_parity, 1'b0);
      end
    end
    drain();
    chk("count_8", bus.count, 16'd8);

    // All-zero AND, then NOT of 1.
    send(3'd0, 32'h0, 32'h0, mk(32'h0, 1'b0));
    send(3'd6, 32'h1, 32'h0, mk(32'hFFFFFFFE, 1'b0));
    drain();
    chk("count_10", bus.count, 16'd10);

    // Backpressure: two accepted, third stalls, first result held.
    for (int i = 0; i < 4; i++) begin
      bpa[i] = $urandom; bpb[i] = $urandom;
      bp[i] = model(3'(i + 1), bpa[i], bpb[i]);
    end
    bus.out_ready = 1'b0;
    send(3'd1, bpa[0], bpb[0], bp[0]);
    send(3'd2, bpa[1], bpb[1], bp[1]);
    bus.in_valid = 1'b1; bus.op = 3'd3; bus.a = bpa[2]; bus.b = bpb[2];
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_hold", bus.out, bp[0].res);
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    send(3'd3, bpa[2], bpb[2], bp[2]);
    send(3'd4, bpa[3], bpb[3], bp[3]);
    drain();
    chk("count_14", bus.count, 16'd14);

    // Random ops under random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          rop = 3'($urandom_range(0, 7)); ra = $urandom; rb = $urandom;
          send(rop, ra, rb, model(rop, ra, rb));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock); #2;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    chk("count_38", bus.count, 16'd38);

    // Asynchronous reset with both stages full.
    bus.out_ready = 1'b0;
    send(3'd2, 32'h12345678, 32'h0F0F0F0F, model(3'd2, 32'h12345678, 32'h0F0F0F0F));
    send(3'd1, 32'hA5A5A5A5, 32'h00000001, model(3'd1, 32'hA5A5A5A5, 32'h00000001));
    bus.in_valid = 1'b0;
    cycles(1);
    chk("full_valid", bus.out_valid, 1'b1);
    chk("full_in_ready", bus.in_ready, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_in_ready", bus.in_ready, 1'b1);
    chk("arst_count", bus.count, 16'd0);
    q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("no_stale", bus.out_valid, 1'b0);
    end
    chk("post_rst_count", bus.count, 16'd0);

    // COUNT_W=2 instance: five transfers saturate at 3.
    @(posedge clock); #1;
    chk("c2_rst", bus2.count, 2'd0);
    bus2.in_valid = 1'b1; bus2.op = 3'd2; bus2.a = 8'h5A; bus2.b = 8'h0F;
    cycles(4);
    chk("c2_two", bus2.count, 2'd2);
    cycles(1);
    bus2.in_valid = 1'b0;
    cycles(3);
    chk("c2_sat", bus2.count, 2'd3);
    chk("c2_empty", bus2.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
